// File: rtl/pcie_dma_pkg.sv
// Shared DMA TX/RX types: arbiter state encoding and TX beat/FIFO geometry.
package pcie_dma_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam int TX_BEAT_W     = 266;
  localparam int TX_FIFO_DEPTH = 8;
endpackage

// File: rtl/pcie_tx_fifo_arb_rr_pick.sv
// Combinational round-robin selector: first requester after i_last, with wrap-around.
// Zero latency; no backpressure (pure function of the request vector).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_gnt,
  output logic               o_any
);
  int w_idx;

  // Walk downward so the nearest requester after i_last is the final assignment.
  always_comb begin
    o_gnt = i_last;
    w_idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = int'(i_last) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (i_req[w_idx[IDX_W-1:0]]) o_gnt = w_idx[IDX_W-1:0];
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/pcie_tx_fifo_arb.sv
// Packet-level round-robin arbiter pushing NUM_REQ channel streams into one TX beat FIFO.
// 1-cycle grant, then same-cycle push per beat; fifoFull stalls, fifoAlmostFull blocks new grants.
module pcie_tx_fifo_arb
  import pcie_dma_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = TX_BEAT_W,
  parameter int MAX_BEATS = 64,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                      clockCore,
  input  logic                      resetCore,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ-1:0]        reqLast,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic                      fifoPush,
  output logic [DATA_W-1:0]         fifoDataIn,
  input  logic                      fifoFull,
  input  logic                      fifoAlmostFull,
  output logic                      busy,
  output logic [IDX_W-1:0]          owner,
  output logic                      protoErr,
  output logic                      pktDone
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_done;

  logic [IDX_W-1:0]   w_gnt;
  logic               w_any;
  logic               w_xfer;
  logic               w_last;
  logic               w_wdog;
  logic [NUM_REQ-1:0] w_rdy;
  logic [DATA_W-1:0]  w_sel;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req  (reqValid),
    .i_last (r_owner),
    .o_gnt  (w_gnt),
    .o_any  (w_any)
  );

  always_comb begin
    w_rdy = '0;
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IDX_W'(i)) begin
        w_rdy[i] = (r_state == XFER) & ~fifoFull;
        w_sel    = reqData[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_xfer = (r_state == XFER) & reqValid[r_owner] & ~fifoFull;
  assign w_last = reqLast[r_owner];
  // Counter reaching MAX_BEATS on this beat without an end marker trips the watchdog.
  assign w_wdog = ~w_last & (r_cnt == CNT_W'(MAX_BEATS - 1));

  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      r_state <= IDLE;
      r_owner <= IDX_W'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any && !fifoAlmostFull) begin
            r_owner <= w_gnt;
            r_cnt   <= '0;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_xfer) begin
            if (r_cnt != CNT_W'(MAX_BEATS)) r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else if (w_wdog) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign reqReady   = w_rdy;
  assign fifoPush   = w_xfer;
  assign fifoDataIn = w_sel & {DATA_W{w_xfer}};
  assign busy       = (r_state == XFER);
  assign owner      = r_owner;
  assign protoErr   = r_err;
  assign pktDone    = r_done;
endmodule

// File: tb/tb_pcie_tx_fifo_arb.sv
// Randomized channel sources with per-channel expected-beat queues and a negedge monitor model.
module tb_pcie_tx_fifo_arb;
  import pcie_dma_pkg::*;

  localparam int NR   = 4;
  localparam int DW   = TX_BEAT_W;
  localparam int MAXB = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    valid, last, ready;
  logic [NR*DW-1:0] data;
  logic             push, full, af, busy, perr, done;
  logic [DW-1:0]    din;
  logic [1:0]       owner;

  always #5 clk = ~clk;

  pcie_tx_fifo_arb #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BEATS (MAXB),
    .IDX_W     (2)
  ) dut (
    .clockCore      (clk),
    .resetCore      (rst),
    .reqValid       (valid),
    .reqLast        (last),
    .reqData        (data),
    .reqReady       (ready),
    .fifoPush       (push),
    .fifoDataIn     (din),
    .fifoFull       (full),
    .fifoAlmostFull (af),
    .busy           (busy),
    .owner          (owner),
    .protoErr       (perr),
    .pktDone        (done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] expq[NR][$];

  logic [NR-1:0] en;
  logic [NR-1:0] acc;
  int len_min, len_max, gap_pct, full_pct, af_pct;
  bit nolast[NR];
  bit act[NR];
  int plen[NR];
  int pbeat[NR];

  function automatic void chk(string name, logic [DW-1:0] act_v, logic [DW-1:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endfunction

  function automatic int rr_ref(logic [NR-1:0] v, int lo);
    for (int k = 1; k <= NR; k++)
      if (v[(lo + k) % NR]) return (lo + k) % NR;
    return lo;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < 9; k++) d = {d[DW-33:0], $urandom()};
    return d;
  endfunction

  // Reference model: packet-granular round robin, whole-packet ownership, watchdog at MAXB.
  bit            m_busy, m_err, m_done, m_ep;
  int            m_owner, m_cnt;
  logic [NR-1:0] m_rdy;
  logic [DW-1:0] m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_err = 0; m_done = 0; m_owner = NR - 1; m_cnt = 0;
    end else begin
      chk("busy",     DW'(busy),  DW'(m_busy));
      chk("owner",    DW'(owner), DW'(m_owner));
      chk("protoErr", DW'(perr),  DW'(m_err));
      chk("pktDone",  DW'(done),  DW'(m_done));
      m_rdy = (m_busy && !full) ? NR'(1 << m_owner) : '0;
      chk("reqReady", DW'(ready), DW'(m_rdy));
      m_ep = m_busy && valid[m_owner] && !full;
      chk("fifoPush", DW'(push), DW'(m_ep));
      if (m_ep && push) begin
        if (expq[m_owner].size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL push_unexpected: ch%0d pushed %0h with no beat pending", m_owner, din);
        end else begin
          m_e = expq[m_owner].pop_front();
          chk("fifoDataIn", din, m_e);
        end
      end
      m_done = 0;
      if (!m_busy) begin
        if (|valid && !af) begin
          m_owner = rr_ref(valid, m_owner);
          m_busy  = 1;
          m_cnt   = 0;
        end
      end else if (m_ep) begin
        m_cnt++;
        if (last[m_owner]) begin
          m_done = 1; m_busy = 0;
        end else if (m_cnt == MAXB) begin
          m_err = 1; m_busy = 0;
        end
      end
    end
  end

  task automatic step();
    logic [DW-1:0] d;
    @(negedge clk);
    acc = valid & ready;
    @(posedge clk);
    #1;
    full = ($urandom_range(99) < full_pct);
    af   = ($urandom_range(99) < af_pct);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        valid[i] = 1'b0;
        pbeat[i]++;
        if (nolast[i] ? (pbeat[i] == MAXB) : (pbeat[i] == plen[i])) begin
          act[i] = 0;
          if (nolast[i]) begin
            en[i] = 1'b0;
            nolast[i] = 0;
          end
        end
      end
      if (!act[i] && en[i] && $urandom_range(99) >= gap_pct) begin
        act[i]   = 1;
        plen[i]  = $urandom_range(len_max, len_min);
        pbeat[i] = 0;
      end
      if (act[i] && !valid[i] && $urandom_range(99) >= gap_pct) begin
        d = rand_beat();
        data[i*DW +: DW] = d;
        expq[i].push_back(d);
        valid[i] = 1'b1;
        last[i]  = !nolast[i] && (pbeat[i] == plen[i] - 1);
      end
    end
  endtask

  task automatic run_phase(input logic [NR-1:0] e, input int lmin, input int lmax,
                           input int gap, input int fp, input int ap, input int cycles);
    en = e; len_min = lmin; len_max = lmax; gap_pct = gap; full_pct = fp; af_pct = ap;
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_reqReady"},   DW'(ready), '0);
    chk({tag, "_fifoPush"},   DW'(push),  '0);
    chk({tag, "_fifoDataIn"}, din,        '0);
    chk({tag, "_busy"},       DW'(busy),  '0);
    chk({tag, "_protoErr"},   DW'(perr),  '0);
    chk({tag, "_pktDone"},    DW'(done),  '0);
    chk({tag, "_owner"},      DW'(owner), DW'(NR - 1));
  endtask

  initial begin
    rst = 1'b1; valid = '0; last = '0; data = '0; full = 1'b0; af = 1'b0; en = '0; acc = '0;
    len_min = 1; len_max = 1; gap_pct = 0; full_pct = 0; af_pct = 0;
    for (int i = 0; i < NR; i++) begin
      nolast[i] = 0; act[i] = 0; plen[i] = 1; pbeat[i] = 0;
    end
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #3 rst = 1'b0;

    run_phase(4'b0001, 1, 1, 0, 0, 0, 20);     // single-beat ch0 packets
    run_phase(4'b1111, 2, 2, 0, 0, 0, 200);    // continuous 2-beat round robin
    run_phase(4'b1111, 4, 4, 0, 30, 0, 200);   // 4-beat packets under fifoFull stalls
    run_phase(4'b0100, 1, 3, 0, 0, 60, 100);   // almost-full gating of new grants
    run_phase(4'b1111, 1, 8, 30, 25, 20, 1500);
    run_phase(4'b0000, 1, 1, 0, 0, 0, 60);

    nolast[3] = 1;                              // ch3 streams 64 beats with no end marker
    run_phase(4'b1000, 1, 3, 0, 0, 0, 10);
    run_phase(4'b1001, 1, 3, 0, 0, 0, 150);
    chk("protoErr_set", DW'(perr), DW'(1));
    run_phase(4'b0000, 1, 1, 0, 0, 0, 40);
    chk("protoErr_sticky", DW'(perr), DW'(1));

    run_phase(4'b0010, 6, 6, 0, 0, 0, 5);       // ch1 mid-packet when reset hits
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    for (int i = 0; i < NR; i++) begin
      act[i] = 0; nolast[i] = 0; expq[i].delete();
    end
    valid = '0; last = '0;
    @(posedge clk);
    @(posedge clk);
    #4 rst = 1'b0;
    run_phase(4'b0011, 1, 4, 0, 0, 0, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
